// File: rtl/sram_arb_cy6264_pkg.sv
// Shared definitions for the CY6264 SRAM arbiter/sequencer.
//   state_t   : sequencer FSM states
//   PORT0/1   : requester index constants (value of the registered grant bit)
//   ADDR_W    : SRAM address width (8K bytes)
//   BYTE_W    : SRAM data width
//   cnt_width : width of a down-counter that must hold (max - 1) of three lengths
package sram_arb_cy6264_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_ACK      = 3'd5,
        ST_TURN     = 3'd6
    } state_t;

    localparam logic PORT0  = 1'b0;
    localparam logic PORT1  = 1'b1;
    localparam int   ADDR_W = 13;
    localparam int   BYTE_W = 8;

    // Phase counters load (length - 1) and count down to zero, so the widest
    // value they ever hold is max(length) - 1.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sram_arb_cy6264_rr_arb2.sv
// rr_arb2: two-input round-robin grant for the SRAM sequencer.
//   CLK, RST : clock, synchronous active-high reset
//   REQ[1:0] : request per port
//   EN       : arbitration enable (sequencer is idle)
//   GNT[1:0] : one-hot grant, valid only while EN is high
// The last-grant flag resets to port 1 so port 0 wins the first contention.
module rr_arb2
    import sram_arb_cy6264_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] REQ,
    input  logic       EN,
    output logic [1:0] GNT
);

    logic last;     // port index that received the most recent grant

    always_comb begin
        GNT = 2'b00;
        if (EN) begin
            if (REQ == 2'b11)
                GNT = (last == PORT1) ? 2'b01 : 2'b10;
            else
                GNT = REQ;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)
            last <= PORT1;
        else if (GNT != 2'b00)
            last <= GNT[1];
    end

endmodule

// File: rtl/sram_arb_cy6264.sv
// sram_arb_cy6264: round-robin arbiter and access sequencer for one CY6264
// 8Kx8 asynchronous SRAM, clocked from a fast system clock.
//   CLK, RST              : clock, synchronous active-high reset
//   REQx/WEx/Ax/DINx      : per-port request, 1=write, byte address, write data
//   ACKx                  : one-cycle completion strobe for the granted port
//   DOUTx                 : last read data for the port, held until its next read
//   BUSY                  : sequencer not idle
//   nCE1, CE2, nOE, nWE, A: registered SRAM control and address pins
//   D                     : SRAM data bus, driven only during write phases
// Phase lengths: RD_WAIT read-access cycles, WE_WIDTH write-pulse cycles,
// TURN_CYCLES bus-release cycles after a read.
module sram_arb_cy6264
    import sram_arb_cy6264_pkg::*;
#(
    parameter int RD_WAIT     = 6,
    parameter int WE_WIDTH    = 4,
    parameter int TURN_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] A0,
    input  logic [ADDR_W-1:0] A1,
    input  logic [BYTE_W-1:0] DIN0,
    input  logic [BYTE_W-1:0] DIN1,
    output logic              ACK0,
    output logic              ACK1,
    output logic [BYTE_W-1:0] DOUT0,
    output logic [BYTE_W-1:0] DOUT1,
    output logic              BUSY,
    output logic              nCE1,
    output logic              CE2,
    output logic              nOE,
    output logic              nWE,
    output logic [ADDR_W-1:0] A,
    inout  wire  [BYTE_W-1:0] D
);

    if (RD_WAIT < 1 || WE_WIDTH < 1 || TURN_CYCLES < 1) begin : g_bad_param
        $error("sram_arb_cy6264: RD_WAIT, WE_WIDTH and TURN_CYCLES must all be >= 1");
    end

    localparam int CW = cnt_width(RD_WAIT, WE_WIDTH, TURN_CYCLES);
    localparam logic [CW-1:0] RD_LOAD   = CW'(RD_WAIT - 1);
    localparam logic [CW-1:0] WE_LOAD   = CW'(WE_WIDTH - 1);
    localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              cur_port;    // granted port of the access in flight
    logic              cur_we;      // access in flight is a write
    logic [BYTE_W-1:0] wdata;
    logic              d_oe;

    logic [1:0]        gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [BYTE_W-1:0] sel_din;

    rr_arb2 u_arb (
        .CLK (CLK),
        .RST (RST),
        .REQ ({REQ1, REQ0}),
        .EN  (state == ST_IDLE),
        .GNT (gnt)
    );

    // Winner's request fields, captured on the grant edge.
    always_comb begin
        sel_we   = gnt[1] ? WE1  : WE0;
        sel_addr = gnt[1] ? A1   : A0;
        sel_din  = gnt[1] ? DIN1 : DIN0;
    end

    assign D = d_oe ? wdata : {BYTE_W{1'bz}};

    // All pin values are registered alongside the state they belong to, so
    // each pin changes on the same edge the FSM enters the matching phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            cnt   <= '0;
            d_oe  <= 1'b0;
            nCE1  <= 1'b1;
            CE2   <= 1'b0;
            nOE   <= 1'b1;
            nWE   <= 1'b1;
            A     <= '0;
            ACK0  <= 1'b0;
            ACK1  <= 1'b0;
            DOUT0 <= '0;
            DOUT1 <= '0;
            BUSY  <= 1'b0;
        end else begin
            CE2  <= 1'b1;
            ACK0 <= 1'b0;
            ACK1 <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        cur_port <= gnt[1];
                        cur_we   <= sel_we;
                        wdata    <= sel_din;
                        A        <= sel_addr;
                        nCE1     <= 1'b0;
                        BUSY     <= 1'b1;
                        if (sel_we) begin
                            state <= ST_WR_SETUP;
                            d_oe  <= 1'b1;
                        end else begin
                            state <= ST_RD;
                            nOE   <= 1'b0;
                            cnt   <= RD_LOAD;
                        end
                    end
                end

                ST_RD: begin
                    if (cnt == '0) begin
                        // D has been stable for RD_WAIT cycles; capture it
                        // on the edge that closes the access.
                        if (cur_port == PORT1) DOUT1 <= D;
                        else                   DOUT0 <= D;
                        nCE1  <= 1'b1;
                        nOE   <= 1'b1;
                        ACK0  <= (cur_port == PORT0);
                        ACK1  <= (cur_port == PORT1);
                        state <= ST_ACK;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_WR_SETUP: begin
                    nWE   <= 1'b0;
                    cnt   <= WE_LOAD;
                    state <= ST_WR_PULSE;
                end

                ST_WR_PULSE: begin
                    if (cnt == '0) begin
                        nWE   <= 1'b1;
                        state <= ST_WR_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                ST_WR_HOLD: begin
                    nCE1  <= 1'b1;
                    d_oe  <= 1'b0;
                    ACK0  <= (cur_port == PORT0);
                    ACK1  <= (cur_port == PORT1);
                    state <= ST_ACK;
                end

                ST_ACK: begin
                    // Only a read leaves the SRAM driving D, so only a read
                    // needs the bus-release gap before the next grant.
                    if (cur_we) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt   <= TURN_LOAD;
                        state <= ST_TURN;
                    end
                end

                ST_TURN: begin
                    if (cnt == '0) begin
                        BUSY  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    d_oe  <= 1'b0;
                    nCE1  <= 1'b1;
                    nOE   <= 1'b1;
                    nWE   <= 1'b1;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arb_cy6264.sv
// Bench for sram_arb_cy6264: two instances (default timing, and RD_WAIT=3),
// each with its own behavioural CY6264 on its D bus. Stimulus is steered to
// one instance at a time by 'sel'; a reference memory, last-grant flag and
// expected DOUT values are kept per instance.
module tb_sram_arb_cy6264;

    localparam int WEW  = 4;
    localparam int TURN = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req0, req1, we0, we1, sel;
    logic [12:0] a0, a1;
    logic [7:0]  din0, din1;

    logic req0_a, req1_a, req0_b, req1_b;
    assign req0_a = req0 & ~sel;
    assign req1_a = req1 & ~sel;
    assign req0_b = req0 & sel;
    assign req1_b = req1 & sel;

    logic        ack0_a, ack1_a, busy_a, nce1_a, ce2_a, noe_a, nwe_a;
    logic        ack0_b, ack1_b, busy_b, nce1_b, ce2_b, noe_b, nwe_b;
    logic [7:0]  dout0_a, dout1_a, dout0_b, dout1_b;
    logic [12:0] sa_a, sa_b;
    wire  [7:0]  d0, d1;

    sram_arb_cy6264 #(.RD_WAIT(6), .WE_WIDTH(WEW), .TURN_CYCLES(TURN)) dut_a (
        .CLK(clk), .RST(rst), .REQ0(req0_a), .REQ1(req1_a), .WE0(we0), .WE1(we1),
        .A0(a0), .A1(a1), .DIN0(din0), .DIN1(din1), .ACK0(ack0_a), .ACK1(ack1_a),
        .DOUT0(dout0_a), .DOUT1(dout1_a), .BUSY(busy_a), .nCE1(nce1_a), .CE2(ce2_a),
        .nOE(noe_a), .nWE(nwe_a), .A(sa_a), .D(d0));

    sram_arb_cy6264 #(.RD_WAIT(3), .WE_WIDTH(WEW), .TURN_CYCLES(TURN)) dut_b (
        .CLK(clk), .RST(rst), .REQ0(req0_b), .REQ1(req1_b), .WE0(we0), .WE1(we1),
        .A0(a0), .A1(a1), .DIN0(din0), .DIN1(din1), .ACK0(ack0_b), .ACK1(ack1_b),
        .DOUT0(dout0_b), .DOUT1(dout1_b), .BUSY(busy_b), .nCE1(nce1_b), .CE2(ce2_b),
        .nOE(noe_b), .nWE(nwe_b), .A(sa_b), .D(d1));

    // Behavioural SRAMs: drive D while selected and output-enabled, store
    // while selected with nWE low.
    logic [7:0] mem0 [8192];
    logic [7:0] mem1 [8192];
    assign d0 = (!nce1_a && ce2_a && !noe_a && nwe_a) ? mem0[sa_a] : 8'hzz;
    assign d1 = (!nce1_b && ce2_b && !noe_b && nwe_b) ? mem1[sa_b] : 8'hzz;
    always @(posedge clk) if (!nce1_a && ce2_a && !nwe_a) mem0[sa_a] <= d0;
    always @(posedge clk) if (!nce1_b && ce2_b && !nwe_b) mem1[sa_b] <= d1;

    // Observation of the currently selected instance.
    logic        ack0_m, ack1_m, busy_m, nce1_m, ce2_m, noe_m, nwe_m, dz_m;
    logic [7:0]  dout0_m, dout1_m, dval_m;
    logic [12:0] sa_m;
    assign ack0_m  = sel ? ack0_b  : ack0_a;
    assign ack1_m  = sel ? ack1_b  : ack1_a;
    assign busy_m  = sel ? busy_b  : busy_a;
    assign nce1_m  = sel ? nce1_b  : nce1_a;
    assign ce2_m   = sel ? ce2_b   : ce2_a;
    assign noe_m   = sel ? noe_b   : noe_a;
    assign nwe_m   = sel ? nwe_b   : nwe_a;
    assign dout0_m = sel ? dout0_b : dout0_a;
    assign dout1_m = sel ? dout1_b : dout1_a;
    assign sa_m    = sel ? sa_b    : sa_a;
    assign dval_m  = sel ? d1      : d0;
    assign dz_m    = sel ? (d1 === 8'hzz) : (d0 === 8'hzz);

    // Reference model state, indexed by instance.
    int         vectors = 0;
    int         miscompares = 0;
    int         lastg [2];
    logic [7:0] edout [2][2];
    logic [7:0] refm  [2][8192];
    logic [12:0] pool [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            lastg[s] = 1;
            edout[s][0] = 8'h00;
            edout[s][1] = 8'h00;
        end
    endtask

    // Pin-level invariants on both instances, sampled away from the active edge.
    always @(negedge clk) begin
        chk("we_oe_excl_a", 32'(nwe_a | noe_a), 32'(1));
        chk("we_oe_excl_b", 32'(nwe_b | noe_b), 32'(1));
        chk("ack_excl_a", 32'(ack0_a & ack1_a), 32'(0));
        chk("ack_excl_b", 32'(ack0_b & ack1_b), 32'(0));
        if (nce1_a) chk("d_released_a", 32'(d0 === 8'hzz), 32'(1));
        if (nce1_b) chk("d_released_b", 32'(d1 === 8'hzz), 32'(1));
    end

    task automatic check_idle_pins(input string tag, input bit in_rst);
        chk({tag, "_busy"}, 32'(busy_m), 32'(0));
        chk({tag, "_nce1"}, 32'(nce1_m), 32'(1));
        chk({tag, "_ce2"},  32'(ce2_m),  32'(!in_rst));
        chk({tag, "_noe"},  32'(noe_m),  32'(1));
        chk({tag, "_nwe"},  32'(nwe_m),  32'(1));
        chk({tag, "_ack"},  32'({ack1_m, ack0_m}), 32'(0));
        chk({tag, "_dz"},   32'(dz_m), 32'(1));
        if (in_rst) begin
            chk({tag, "_a"},     32'(sa_m), 32'(0));
            chk({tag, "_dout0"}, 32'(dout0_m), 32'(0));
            chk({tag, "_dout1"}, 32'(dout1_m), 32'(0));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_before_req", 32'(busy_m), 32'(0));
    endtask

    // One arbitration round on the selected instance. Edge counts are taken
    // from the grant edge (n = 0); counting the grant cycle itself, a read
    // acks in cycle RD_WAIT+1 and a write in cycle WE_WIDTH+3.
    task automatic run_round(input bit r0, input bit r1, input bit w0, input bit w1,
                             input logic [12:0] ad0, input logic [12:0] ad1,
                             input logic [7:0] dt0, input logic [7:0] dt1,
                             output int won);
        int s, win, n, lo, rdw;
        bit w;
        logic [12:0] adr;
        logic [7:0] dat;
        s   = int'(sel);
        rdw = sel ? 3 : 6;
        wait_idle();
        @(negedge clk);
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        a0 = ad0; a1 = ad1; din0 = dt0; din1 = dt1;
        if (r0 && r1) win = (lastg[s] == 1) ? 0 : 1;
        else          win = r1 ? 1 : 0;
        w   = win ? w1 : w0;
        adr = win ? ad1 : ad0;
        dat = win ? dt1 : dt0;
        @(posedge clk); #1;
        chk("grant_busy", 32'(busy_m), 32'(1));
        req0 = 1'b0; req1 = 1'b0;
        n = 0; lo = 0;
        while (!(ack0_m || ack1_m) && n < 40) begin
            if (w) begin
                if (!nwe_m) lo++;
                if (!nce1_m) chk("wr_data_on_d", 32'(dval_m), 32'(dat));
                chk("wr_addr", 32'(sa_m), 32'(adr));
            end else begin
                chk("rd_addr", 32'(sa_m), 32'(adr));
            end
            @(posedge clk); #1;
            n++;
        end
        chk(w ? "wr_ack_latency" : "rd_ack_latency", 32'(n), 32'(w ? WEW + 2 : rdw));
        chk("ack0_port", 32'(ack0_m), 32'(win == 0));
        chk("ack1_port", 32'(ack1_m), 32'(win == 1));
        if (w) begin
            chk("nwe_low_cycles", 32'(lo), 32'(WEW));
            refm[s][adr] = dat;
        end else begin
            edout[s][win] = refm[s][adr];
        end
        chk("dout0", 32'(dout0_m), 32'(edout[s][0]));
        chk("dout1", 32'(dout1_m), 32'(edout[s][1]));
        lastg[s] = win;
        won = win;
        if (!w) begin
            for (int t = 0; t < TURN; t++) begin
                @(posedge clk); #1;
                chk("turn_busy", 32'(busy_m), 32'(1));
                chk("turn_noe",  32'(noe_m),  32'(1));
                chk("turn_nce1", 32'(nce1_m), 32'(1));
                chk("turn_dz",   32'(dz_m),   32'(1));
                chk("turn_noack", 32'(ack0_m | ack1_m), 32'(0));
            end
        end
        @(posedge clk); #1;
        chk("back_to_idle", 32'(busy_m), 32'(0));
        chk("ack_one_cycle", 32'(ack0_m | ack1_m), 32'(0));
    endtask

    initial begin
        int won, p, r;
        logic [7:0] v;
        rst = 1'b1; sel = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        a0 = '0; a1 = '0; din0 = '0; din1 = '0;
        model_reset();

        // Reset values on both instances, then idle after release.
        repeat (3) @(posedge clk);
        #1;
        check_idle_pins("rst_a", 1'b1);
        sel = 1'b1; #1;
        check_idle_pins("rst_b", 1'b1);
        @(negedge clk);
        rst = 1'b0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_pins("idle_a", 1'b0);
        sel = 1'b1; #1;
        check_idle_pins("idle_b", 1'b0);
        sel = 1'b0; #1;

        // Port-0 write then port-1 read of the same byte.
        run_round(1'b1, 1'b0, 1'b1, 1'b0, 13'h1ABC, 13'h0, 8'h5A, 8'h00, won);
        run_round(1'b0, 1'b1, 1'b0, 1'b0, 13'h0, 13'h1ABC, 8'h00, 8'h00, won);
        chk("readback_1abc", 32'(dout1_m), 32'(8'h5A));

        // Both ports requesting continuously: alternate starting with port 0.
        for (int i = 0; i < 4; i++) begin
            v = 8'($urandom);
            run_round(1'b1, 1'b1, 1'b1, 1'b0, 13'h1ABC, 13'h1ABC, v, 8'h00, won);
            chk("rr_order", 32'(won), 32'(i % 2));
        end

        // Read on port 0 followed by write on port 1 (turnaround checked in round).
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 13'h1ABC, 13'h0, 8'h00, 8'h00, won);
        run_round(1'b0, 1'b1, 1'b0, 1'b1, 13'h0, 13'h1ABC, 8'h00, 8'h3C, won);

        // Seed a small address pool, then random traffic over it.
        for (int i = 0; i < 8; i++) begin
            pool[i] = 13'($urandom_range(13'h0800, 13'h0FFF));
            v = 8'($urandom);
            p = i % 2;
            run_round(p == 0, p == 1, 1'b1, 1'b1, pool[i], pool[i], v, v, won);
        end
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(1, 3);
            run_round(r[0], r[1], 1'($urandom), 1'($urandom),
                      pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
                      8'($urandom), 8'($urandom), won);
        end

        // Reset during the second write-pulse cycle.
        wait_idle();
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; a0 = 13'h0777; din0 = 8'hA5;
        @(posedge clk); #1;
        chk("mw_grant", 32'(busy_m), 32'(1));
        req0 = 1'b0;
        @(posedge clk); #1;
        chk("mw_pulse1", 32'(nwe_m), 32'(0));
        @(posedge clk); #1;
        chk("mw_pulse2", 32'(nwe_m), 32'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mw_nwe",  32'(nwe_m),  32'(1));
        chk("mw_nce1", 32'(nce1_m), 32'(1));
        chk("mw_dz",   32'(dz_m),   32'(1));
        chk("mw_busy", 32'(busy_m), 32'(0));
        chk("mw_ce2",  32'(ce2_m),  32'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("mw_no_ack", 32'(ack0_m | ack1_m), 32'(0));
        end
        run_round(1'b1, 1'b1, 1'b1, 1'b1, pool[0], pool[1], 8'h11, 8'h22, won);
        chk("post_rst_winner", 32'(won), 32'(0));
        run_round(1'b0, 1'b1, 1'b0, 1'b0, 13'h0, pool[0], 8'h00, 8'h00, won);
        chk("post_rst_read", 32'(dout1_m), 32'(8'h11));

        // Shortened read wait on the second instance.
        sel = 1'b1; #1;
        run_round(1'b1, 1'b0, 1'b1, 1'b0, 13'h0123, 13'h0, 8'hC3, 8'h00, won);
        run_round(1'b0, 1'b1, 1'b0, 1'b0, 13'h0, 13'h0123, 8'h00, 8'h00, won);
        chk("rw3_readback", 32'(dout1_m), 32'(8'hC3));
        run_round(1'b1, 1'b1, 1'b0, 1'b0, 13'h0123, 13'h0123, 8'h00, 8'h00, won);
        chk("rw3_rr", 32'(won), 32'(0));
        chk("rw3_dout0", 32'(dout0_m), 32'(8'hC3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
